dffram_stream: RTL and testbench
================================

# dffram_stream

Parametrised byte-streamed flip-flop RAM. It is the successor to the fixed 32x32 RAM32 tile wrapper. Storage is a generic array of WORDS x BYTES_PER_WORD bytes, accessed through an internal byte pointer with optional auto-increment. A registered read port and a self-timed CLEAR sequencer allow a whole memory image to be streamed over an 8-bit pin interface. It sits directly behind the chip-level ui/uio pins, in place of the single-access RAM wrapper.

## Interface
Parameters:
- WORDS, 32, number of words; power of two, 2..64.
- BYTES_PER_WORD, 4, bytes per word; one of 1, 2, 4.
- AUTO_INC, 1, 1 = pointer increments after each WRITE/READ; 0 = pointer is held.
- Derived: SIZE = WORDS*BYTES_PER_WORD (≤256); AW = log2(SIZE).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- cmd  in  3  command: 000 NOP, 001 SET_ADDR, 010 WRITE, 011 READ, 100 CLEAR, 101–111 NOP.
- din  in  8  address byte (SET_ADDR) or data byte (WRITE).
- dout  out  8  last byte read.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- busy  out  1  CLEAR in progress.
- ptr  out  AW  current byte pointer.

## Operation
- Byte address b maps to word b>>log2(BYTES_PER_WORD), lane b[log2(BYTES_PER_WORD)-1:0], with little-endian lane order.
- Storage flops have no reset; contents after reset are undefined.
- Commands are sampled only on clock edges where ena=1 and busy=0. Otherwise cmd is ignored (treated as NOP).
- SET_ADDR: ptr <= din[AW-1:0]. Upper din bits are discarded, so the address wraps modulo SIZE.
- WRITE: mem[ptr] <= din, touching only that byte lane. If AUTO_INC=1, ptr <= ptr+1 mod SIZE.
- READ: dout <= mem[ptr]; dout_valid=1 for the next cycle. If AUTO_INC=1, ptr <= ptr+1 mod SIZE.
- dout holds its value until the next READ.
- CLEAR: the FSM goes IDLE -> CLR. An internal counter c walks 0..SIZE-1, writing 0x00 to one byte per enabled cycle. After writing c=SIZE-1 the FSM returns to IDLE.
- CLEAR does not modify ptr.
- FSM states:
  - IDLE: busy=0.
  - CLR: busy=1. Advances only while ena=1. Exits after the last byte is written.
- Pointer wrap: ptr=SIZE-1 followed by WRITE/READ with AUTO_INC gives ptr=0. No flag is raised.
- ena low: ptr, dout, FSM and c all hold, and dout_valid is forced to 0 on that cycle. CLR resumes where it stopped.

## Timing
- Reset values: ptr=0, dout=0x00, dout_valid=0, busy=0, FSM=IDLE, c=0.
- SET_ADDR / WRITE: effect is visible on ptr and in memory after the sampling edge. A READ on the next cycle returns the written byte.
- READ latency is 1 cycle. With cmd=READ at edge N, dout and dout_valid change at edge N and are observed during cycle N+1. dout_valid drops after one cycle unless READ is repeated.
- Back-to-back READs with AUTO_INC stream one byte per cycle, and dout_valid stays high continuously.
- CLEAR timing:
  - busy rises at the sampling edge and stays high for exactly SIZE enabled cycles.
  - Commands presented while busy are dropped, not queued.
  - The first accepted command is at the edge where busy is sampled 0.
- rst_n asserted mid-CLEAR aborts immediately: busy=0, IDLE, ptr=0. Memory is partially cleared, and its contents are not guaranteed.
- rst_n asserted mid-READ clears dout and dout_valid asynchronously.

## Test plan
- Reset: hold rst_n=0 with no clock -> ptr=0, dout=0x00, dout_valid=0, busy=0. Release, then issue 4 NOPs -> outputs unchanged.
- Streamed write/read: SET_ADDR 0x05, WRITE 0xA1, 0xB2, 0xC3 -> ptr=0x08. Then SET_ADDR 0x05 and 3 READs -> dout 0xA1, 0xB2, 0xC3 on consecutive cycles, dout_valid high 3 cycles, other lanes of word 1 unchanged.
- Wrap: SET_ADDR 0xFF (SIZE=128) -> ptr=0x7F. WRITE 0x5A -> ptr=0x00. SET_ADDR 0x7F, READ -> 0x5A.
- AUTO_INC=0 instance: SET_ADDR 3, WRITE 0x11, WRITE 0x22 -> ptr stays 3. READ -> 0x22.
- CLEAR: fill all bytes with 0xFF, then CLEAR -> busy high for exactly SIZE cycles, and a WRITE issued during busy has no effect. Read all bytes afterwards -> all 0x00, ptr unchanged.
- CLEAR with ena toggling and reset: ena low for 10 cycles mid-CLEAR -> busy lasts SIZE+10 cycles. In a second run, rst_n low at c=20 -> busy=0 immediately and ptr=0.

Source files
------------

// File: rtl/dffram_stream_if.sv
// Pin-side bus of the byte-streamed flip-flop RAM.
//   ena        : global enable, low freezes the RAM
//   cmd        : 3-bit command (NOP, SET_ADDR, WRITE, READ, CLEAR)
//   din        : address byte (SET_ADDR) or data byte (WRITE)
//   dout       : last byte read
//   dout_valid : one-cycle pulse when dout is updated
//   busy       : CLEAR sequence in progress
//   ptr        : current byte pointer, AW bits
interface dffram_stream_if #(
  parameter int unsigned AW = 7
) ();
  logic          ena;
  logic [2:0]    cmd;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          dout_valid;
  logic          busy;
  logic [AW-1:0] ptr;

  // Driver side (pins / host).
  modport master (
    output ena, cmd, din,
    input  dout, dout_valid, busy, ptr
  );

  // RAM side.
  modport slave (
    input  ena, cmd, din,
    output dout, dout_valid, busy, ptr
  );
endinterface

// File: rtl/dffram_stream.sv
// Parametrised byte-streamed flip-flop RAM.
// Storage is WORDS x BYTES_PER_WORD bytes (little-endian lanes), reached
// through a byte pointer that optionally auto-increments after WRITE/READ.
// A registered read port and a self-timed CLEAR sequencer let a whole memory
// image be streamed over an 8-bit interface.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (control state only, not storage)
//   bus   : dffram_stream_if slave modport (ena/cmd/din in, dout/dout_valid/busy/ptr out)
module dffram_stream #(
  parameter int unsigned WORDS          = 32,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned AUTO_INC       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dffram_stream_if.slave  bus
);

  localparam int unsigned SIZE = WORDS * BYTES_PER_WORD;
  localparam int unsigned AW   = $clog2(SIZE);
  localparam int unsigned LW   = $clog2(BYTES_PER_WORD);
  localparam int unsigned WW   = AW - LW;
  // Lane index needs at least one bit even for single-byte words.
  localparam int unsigned LIW  = (LW == 0) ? 1 : LW;

  localparam logic [2:0] CMD_SET_ADDR = 3'b001;
  localparam logic [2:0] CMD_WRITE    = 3'b010;
  localparam logic [2:0] CMD_READ     = 3'b011;
  localparam logic [2:0] CMD_CLEAR    = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] clr_cnt_q;
  logic [7:0]    dout_q;
  logic          dout_valid_q;
  logic          busy_q;

  // Storage flops: deliberately not reset.
  logic [BYTES_PER_WORD-1:0][7:0] mem_q [WORDS];

  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [7:0]    wr_data_c;
  logic [WW-1:0] wr_word_c;
  logic [LIW-1:0] wr_lane_c;
  logic [WW-1:0] rd_word_c;
  logic [LIW-1:0] rd_lane_c;
  logic [7:0]    rd_byte_c;

  // Single write port shared by host WRITE and the CLEAR sequencer.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = ptr_q;
    wr_data_c = bus.din;
    if (bus.ena) begin
      if (state_q == S_CLR) begin
        wr_en_c   = 1'b1;
        wr_addr_c = clr_cnt_q;
        wr_data_c = 8'h00;
      end else if (bus.cmd == CMD_WRITE) begin
        wr_en_c = 1'b1;
      end
    end
  end

  // Byte address -> word index (upper bits) and lane (lower bits).
  assign wr_word_c = wr_addr_c[AW-1:LW];
  assign rd_word_c = ptr_q[AW-1:LW];

  generate
    if (LW == 0) begin : g_single_lane
      assign wr_lane_c = '0;
      assign rd_lane_c = '0;
    end else begin : g_multi_lane
      assign wr_lane_c = wr_addr_c[LW-1:0];
      assign rd_lane_c = ptr_q[LW-1:0];
    end
  endgenerate

  assign rd_byte_c = mem_q[rd_word_c][rd_lane_c];

  // Byte-lane write into the storage array.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_word_c][wr_lane_c] <= wr_data_c;
    end
  end

  // Control FSM: pointer, read register and CLEAR sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      clr_cnt_q    <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // dout_valid is a pulse; a frozen cycle also forces it low.
      dout_valid_q <= 1'b0;
      if (bus.ena) begin
        case (state_q)
          S_IDLE: begin
            case (bus.cmd)
              CMD_SET_ADDR: ptr_q <= bus.din[AW-1:0];
              CMD_WRITE: begin
                if (AUTO_INC != 0) ptr_q <= ptr_q + AW'(1);
              end
              CMD_READ: begin
                dout_q       <= rd_byte_c;
                dout_valid_q <= 1'b1;
                if (AUTO_INC != 0) ptr_q <= ptr_q + AW'(1);
              end
              CMD_CLEAR: begin
                state_q   <= S_CLR;
                busy_q    <= 1'b1;
                clr_cnt_q <= '0;
              end
              default: ;
            endcase
          end
          S_CLR: begin
            // Byte clr_cnt_q is zeroed on this edge by the write port.
            if (clr_cnt_q == AW'(SIZE - 1)) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              clr_cnt_q <= '0;
            end else begin
              clr_cnt_q <= clr_cnt_q + AW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.ptr        = ptr_q;

endmodule

// File: tb/tb_dffram_stream.sv
// Directed bench for dffram_stream: a default instance (32x4, AUTO_INC=1,
// SIZE=128) and a small hold-pointer instance (4x2, AUTO_INC=0, SIZE=8).
module tb_dffram_stream;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] SETA = 3'b001;
  localparam logic [2:0] WR   = 3'b010;
  localparam logic [2:0] RD   = 3'b011;
  localparam logic [2:0] CLR  = 3'b100;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  always #5 if (clk_run) clk = ~clk;

  dffram_stream_if #(.AW(7)) bus_a ();
  dffram_stream_if #(.AW(3)) bus_b ();

  dffram_stream #(.WORDS(32), .BYTES_PER_WORD(4), .AUTO_INC(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dffram_stream #(.WORDS(4), .BYTES_PER_WORD(2), .AUTO_INC(0)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one command per instance for one edge; sample 1 ns after the edge.
  task automatic step(input logic [2:0] ca, input logic [7:0] da,
                      input logic [2:0] cb = 3'b000, input logic [7:0] db = 8'h00);
    @(negedge clk);
    bus_a.cmd = ca; bus_a.din = da;
    bus_b.cmd = cb; bus_b.din = db;
    @(posedge clk);
    #1;
  endtask

  int cnt;
  logic [7:0] acc;
  logic       dv_all;

  initial begin
    bus_a.ena = 1'b1; bus_a.cmd = NOP; bus_a.din = 8'h00;
    bus_b.ena = 1'b1; bus_b.cmd = NOP; bus_b.din = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    // Reset with no clock running.
    chk("rst_ptr",   32'(bus_a.ptr), 32'h0);
    chk("rst_dout",  32'(bus_a.dout), 32'h0);
    chk("rst_dv",    32'(bus_a.dout_valid), 32'h0);
    chk("rst_busy",  32'(bus_a.busy), 32'h0);
    chk("rst_ptr_b", 32'(bus_b.ptr), 32'h0);

    clk_run = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(NOP, 8'h00);
    chk("nop_ptr",  32'(bus_a.ptr), 32'h0);
    chk("nop_dout", 32'(bus_a.dout), 32'h0);
    chk("nop_dv",   32'(bus_a.dout_valid), 32'h0);
    chk("nop_busy", 32'(bus_a.busy), 32'h0);

    // Known neighbours of the streamed bytes.
    step(SETA, 8'h04); step(WR, 8'h44);
    step(SETA, 8'h08); step(WR, 8'h88);
    // Streamed write of bytes 5..7.
    step(SETA, 8'h05);
    chk("seta_ptr", 32'(bus_a.ptr), 32'h05);
    step(WR, 8'hA1); step(WR, 8'hB2); step(WR, 8'hC3);
    chk("wr_ptr", 32'(bus_a.ptr), 32'h08);
    // Streamed read back.
    step(SETA, 8'h05);
    step(RD, 8'h00);
    chk("rd0_dout", 32'(bus_a.dout), 32'hA1); chk("rd0_dv", 32'(bus_a.dout_valid), 32'h1);
    step(RD, 8'h00);
    chk("rd1_dout", 32'(bus_a.dout), 32'hB2); chk("rd1_dv", 32'(bus_a.dout_valid), 32'h1);
    step(RD, 8'h00);
    chk("rd2_dout", 32'(bus_a.dout), 32'hC3); chk("rd2_dv", 32'(bus_a.dout_valid), 32'h1);
    chk("rd_ptr", 32'(bus_a.ptr), 32'h08);
    step(RD, 8'h00);
    chk("rd_b8", 32'(bus_a.dout), 32'h88);
    step(NOP, 8'h00);
    chk("hold_dv",   32'(bus_a.dout_valid), 32'h0);
    chk("hold_dout", 32'(bus_a.dout), 32'h88);
    step(SETA, 8'h04); step(RD, 8'h00);
    chk("rd_b4", 32'(bus_a.dout), 32'h44);

    // ena low freezes pointer and output, kills dout_valid.
    bus_a.ena = 1'b0;
    step(RD, 8'h00);
    chk("frz_ptr",  32'(bus_a.ptr), 32'h05);
    chk("frz_dv",   32'(bus_a.dout_valid), 32'h0);
    chk("frz_dout", 32'(bus_a.dout), 32'h44);
    bus_a.ena = 1'b1;

    // Address wrap.
    step(SETA, 8'hFF);
    chk("wrap_seta", 32'(bus_a.ptr), 32'h7F);
    step(WR, 8'h5A);
    chk("wrap_ptr", 32'(bus_a.ptr), 32'h00);
    step(SETA, 8'h7F); step(RD, 8'h00);
    chk("wrap_rd",  32'(bus_a.dout), 32'h5A);
    chk("wrap_rdp", 32'(bus_a.ptr), 32'h00);

    // Hold-pointer instance.
    step(NOP, 8'h00, SETA, 8'h03);
    step(NOP, 8'h00, WR, 8'h11);
    step(NOP, 8'h00, WR, 8'h22);
    chk("hold_wr_ptr", 32'(bus_b.ptr), 32'h3);
    step(NOP, 8'h00, RD, 8'h00);
    chk("hold_rd",     32'(bus_b.dout), 32'h22);
    chk("hold_rd_ptr", 32'(bus_b.ptr), 32'h3);
    step(NOP, 8'h00, SETA, 8'h0E);
    chk("hold_seta_wrap", 32'(bus_b.ptr), 32'h6);

    // Fill, then CLEAR with a dropped WRITE during busy.
    step(SETA, 8'h00);
    for (int i = 0; i < 128; i++) step(WR, 8'hFF);
    step(SETA, 8'h10);
    step(RD, 8'h00);
    chk("fill_rd", 32'(bus_a.dout), 32'hFF);
    step(SETA, 8'h10);
    step(CLR, 8'h00);
    cnt = bus_a.busy ? 1 : 0;
    for (int k = 0; k < 1000 && bus_a.busy; k++) begin
      if (k == 0) step(WR, 8'h77); else step(NOP, 8'h00);
      if (bus_a.busy) cnt++;
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd128);
    chk("clr_ptr", 32'(bus_a.ptr), 32'h10);
    step(SETA, 8'h00);
    acc = 8'h00; dv_all = 1'b1;
    for (int i = 0; i < 128; i++) begin
      step(RD, 8'h00);
      acc = acc | bus_a.dout;
      dv_all = dv_all & bus_a.dout_valid;
    end
    chk("clr_all_zero", 32'(acc), 32'h0);
    chk("clr_stream_dv", 32'(dv_all), 32'h1);
    chk("clr_rd_ptr", 32'(bus_a.ptr), 32'h00);

    // CLEAR stretched by 10 frozen cycles.
    step(CLR, 8'h00);
    cnt = bus_a.busy ? 1 : 0;
    for (int k = 0; k < 1000 && bus_a.busy; k++) begin
      bus_a.ena = !(k >= 20 && k < 30);
      step(NOP, 8'h00);
      if (bus_a.busy) cnt++;
    end
    bus_a.ena = 1'b1;
    chk("clr_ena_cycles", 32'(cnt), 32'd138);

    // Reset during a READ pulse.
    step(SETA, 8'h02); step(WR, 8'h3C);
    step(SETA, 8'h02); step(RD, 8'h00);
    chk("pre_rst_dout", 32'(bus_a.dout), 32'h3C);
    chk("pre_rst_dv",   32'(bus_a.dout_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdrst_dout", 32'(bus_a.dout), 32'h0);
    chk("rdrst_dv",   32'(bus_a.dout_valid), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Reset at c=20 of a CLEAR.
    step(SETA, 8'h33);
    step(CLR, 8'h00);
    for (int k = 0; k < 20; k++) step(NOP, 8'h00);
    chk("clr20_busy", 32'(bus_a.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("clrrst_busy", 32'(bus_a.busy), 32'h0);
    chk("clrrst_ptr",  32'(bus_a.ptr), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step(SETA, 8'h44);
    chk("post_rst_cmd", 32'(bus_a.ptr), 32'h44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
